alu_mul_sequencer: RTL and testbench

Multi-cycle sequencer that performs 32x32 -> 64-bit unsigned multiplication (UMULL semantics) by time-sharing the processor's existing 2-bit-op ALU in ADD mode for 32 shift-add iterations. It sits beside the datapath ALU; while busy it takes ownership of the ALU operand and control inputs through a select signal, then returns the ALU to the normal datapath. Results and N/Z flags are held until the next accepted start.

---
 rtl/alu_mul_sequencer_if.sv | 32 +++
 rtl/alu_mul_sequencer.sv | 95 +++++++++
 tb/tb_alu_mul_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_if.sv
// rtl/alu_mul_sequencer_if.sv - request/result and ALU-sharing signals of the multiply sequencer
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             flag_n;
  logic             flag_z;
  logic             alu_sel;
  logic [WIDTH-1:0] alu_src_a;
  logic [WIDTH-1:0] alu_src_b;
  logic [1:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  modport master (
    output start, op_a, op_b, alu_result, alu_carry,
    input  busy, done, result_hi, result_lo, flag_n, flag_z,
           alu_sel, alu_src_a, alu_src_b, alu_control
  );

  modport slave (
    input  start, op_a, op_b, alu_result, alu_carry,
    output busy, done, result_hi, result_lo, flag_n, flag_z,
           alu_sel, alu_src_a, alu_src_b, alu_control
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - 32x32->64 unsigned multiply by 32 shift-add passes through the shared ALU
module alu_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  alu_mul_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [4:0]       count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy_r;
  logic             done_r;
  logic             sel_r;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             fn_r;
  logic             fz_r;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;

  // The ALU carry becomes the new top bit, so the 33-bit partial sum is never truncated.
  always_comb begin
    hi_nx = {bus.alu_carry, bus.alu_result[WIDTH-1:1]};
    lo_nx = {bus.alu_result[0], lo[WIDTH-1:1]};
  end

  assign bus.alu_src_a   = sel_r ? hi : '0;
  assign bus.alu_src_b   = (sel_r && lo[0]) ? mcand : '0;
  assign bus.alu_control = 2'b00;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.result_hi   = res_hi;
  assign bus.result_lo   = res_lo;
  assign bus.flag_n      = fn_r;
  assign bus.flag_z      = fz_r;
  assign bus.alu_sel     = sel_r;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sel_r  <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
      fn_r   <= 1'b0;
      fz_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            mcand  <= bus.op_a;
            lo     <= bus.op_b;
            hi     <= '0;
            count  <= '0;
            state  <= BUSY;
            busy_r <= 1'b1;
            sel_r  <= 1'b1;
          end
        end
        BUSY: begin
          hi    <= hi_nx;
          lo    <= lo_nx;
          count <= count + 5'd1;
          // Results are captured from the last pass's next-state values, not the registers.
          if (count == 5'd31) begin
            state  <= DONE;
            sel_r  <= 1'b0;
            done_r <= 1'b1;
            res_hi <= hi_nx;
            res_lo <= lo_nx;
            fn_r   <= hi_nx[WIDTH-1];
            fz_r   <= ({hi_nx, lo_nx} == '0);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - directed and random checks of the multiply sequencer against a product model
module tb_alu_mul_sequencer;
  logic clk;
  logic reset;
  int   tests;
  int   failures;

  alu_mul_sequencer_if #(.WIDTH(32)) bus ();

  alu_mul_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Datapath ALU stand-in: ADD only, with carry out.
  logic [32:0] alu_sum;
  assign alu_sum        = {1'b0, bus.alu_src_a} + {1'b0, bus.alu_src_b};
  assign bus.alu_result = alu_sum[31:0];
  assign bus.alu_carry  = alu_sum[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  64'(bus.busy), 64'd0);
    check({tag, "_done"},  64'(bus.done), 64'd0);
    check({tag, "_sel"},   64'(bus.alu_sel), 64'd0);
    check({tag, "_srca"},  64'(bus.alu_src_a), 64'd0);
    check({tag, "_srcb"},  64'(bus.alu_src_b), 64'd0);
    check({tag, "_ctl"},   64'(bus.alu_control), 64'd0);
    check({tag, "_res"},   {bus.result_hi, bus.result_lo}, 64'd0);
    check({tag, "_flags"}, {62'd0, bus.flag_n, bus.flag_z}, 64'd0);
  endtask

  // Starts one multiply and follows it to completion; optionally pokes start while busy/done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag, input bit poke);
    logic [63:0] exp;
    int cyc;
    int sel_cnt;
    int ctl_bad;
    exp = {32'd0, a} * {32'd0, b};
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    sel_cnt = 0;
    ctl_bad = 0;
    while (!bus.done && cyc < 100) begin
      if (bus.alu_sel) sel_cnt++;
      if (bus.alu_control != 2'b00) ctl_bad++;
      if (poke && cyc == 5) begin
        bus.start = 1'b1;
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd33);
    check({tag, "_selcycles"}, 64'(sel_cnt), 64'd32);
    check({tag, "_ctl"}, 64'(ctl_bad), 64'd0);
    check({tag, "_sel_in_done"}, 64'(bus.alu_sel), 64'd0);
    check({tag, "_product"}, {bus.result_hi, bus.result_lo}, exp);
    check({tag, "_flag_n"}, 64'(bus.flag_n), 64'(exp[63]));
    check({tag, "_flag_z"}, 64'(bus.flag_z), 64'(exp == 64'd0));
    if (poke) begin
      bus.start = 1'b1;
      bus.op_a  = 32'd3;
      bus.op_b  = 32'd3;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
    check({tag, "_busy_drop"}, 64'(bus.busy), 64'd0);
    if (poke) begin
      int extra;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.busy || bus.done) extra++;
      end
      check({tag, "_no_second_op"}, 64'(extra), 64'd0);
      check({tag, "_held"}, {bus.result_hi, bus.result_lo}, exp);
    end
  endtask

  initial begin
    tests = 0;
    failures = 0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    // Reset held two cycles with start asserted must not accept.
    reset = 1'b0;
    bus.start = 1'b1;
    bus.op_a  = 32'd11;
    bus.op_b  = 32'd13;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("reset_release_busy", 64'(bus.busy), 64'd0);

    run_op(32'd7, 32'd6, "basic", 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max", 1'b0);
    run_op(32'h1234_5678, 32'd0, "zero", 1'b0);
    run_op(32'd123456, 32'd654321, "ignored_start", 1'b1);

    // Reset during iteration 10 aborts the product.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 32'd5;
    bus.op_b  = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("midreset");
    reset = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.done || bus.busy) seen++;
      end
      check("midreset_no_done", 64'(seen), 64'd0);
    end
    run_op(32'd9, 32'd9, "after_reset", 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i == 0) rb = 32'h8000_0001;
      run_op(ra, rb, $sformatf("rand%0d", i), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
